// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-side definitions.
//   XLEN          - default address/instruction width
//   PC_INC        - sequential fetch stride in bytes
//   fetch_entry_t - one prefetch buffer slot {pc, inst, filled}
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int PC_INC = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order prefetch FIFO. An entry is allocated when its request
// is accepted, filled when its response arrives, and popped by IF/ID.
//   clk, reset     - clock, async active-high reset
//   clear          - drop every entry (redirect)
//   alloc/alloc_pc - allocate tail entry {pc, filled=0}
//   fill/fill_data - write the oldest unfilled entry
//   pop            - free the head entry
//   head           - head entry contents
//   not_empty/full - occupancy flags
// Entry width follows riscv_pkg::XLEN.
module fetch_buffer
  import riscv_pkg::XLEN;
  import riscv_pkg::fetch_entry_t;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  output fetch_entry_t    head,
  output logic            not_empty,
  output logic            full
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  head_ptr, tail_ptr, fill_ptr;
  logic [PW:0]    count;

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      // Stale filled bits are harmless: allocation rewrites the whole entry.
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
    end else begin
      if (fill) begin
        mem[fill_ptr].inst   <= fill_data;
        mem[fill_ptr].filled <= 1'b1;
        fill_ptr             <= fill_ptr + 1'b1;
      end
      // Fill and alloc never target the same slot: a slot at the tail is
      // either free or already filled.
      if (alloc) begin
        mem[tail_ptr] <= '{pc: alloc_pc, inst: '0, filled: 1'b0};
        tail_ptr      <= tail_ptr + 1'b1;
      end
      if (pop) head_ptr <= head_ptr + 1'b1;
      count <= count + (PW+1)'(alloc) - (PW+1)'(pop);
    end
  end

  assign head      = mem[head_ptr];
  assign not_empty = (count != '0);
  assign full      = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: instruction fetch with a DEPTH-entry prefetch buffer
// feeding the IF/ID pipeline register.
//   clk, reset                    - clock, async active-high reset
//   pc_branch, pc_src             - redirect target / one-cycle strobe
//   IF_flush                      - bubble IF/ID
//   IF_ID_write                   - decode advances IF/ID (0 = stall)
//   imem_req_valid/ready/addr     - fetch request channel
//   imem_rsp_valid/data           - in-order fetch responses
//   IF_ID_valid/pc/inst           - IF/ID register
module if_prefetch_unit
  import riscv_pkg::PC_INC;
  import riscv_pkg::fetch_entry_t;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_branch,
  input  logic            pc_src,
  input  logic            IF_flush,
  input  logic            IF_ID_write,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            IF_ID_valid,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic [XLEN-1:0] IF_ID_inst
);

  // Outstanding count can exceed DEPTH after redirects (old requests still in
  // flight while new ones are issued), so it gets headroom and saturates.
  localparam int OW = $clog2(DEPTH) + 4;

  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outst, discard;
  logic            req_fire, rsp_keep, pop, head_rdy;
  logic            buf_full, buf_not_empty;
  fetch_entry_t    head;

  assign head_rdy = buf_not_empty & head.filled;
  // A flush discards the IF/ID slot but must not consume a buffered entry.
  assign pop      = IF_ID_write & head_rdy & ~IF_flush;

  // A pop frees a slot this cycle, so a full buffer can still issue.
  assign imem_req_valid = ~reset & ~pc_src & (~buf_full | pop) & (outst != '1);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses in the redirect cycle belong to the old path; the clear drops
  // their entries anyway.
  assign rsp_keep = imem_rsp_valid & (discard == '0) & ~pc_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      outst    <= '0;
      discard  <= '0;
    end else begin
      if (pc_src)        fetch_pc <= pc_branch & ~XLEN'(3);
      else if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_INC);

      outst <= outst + OW'(req_fire) - OW'(imem_rsp_valid);

      // Everything still in flight after this cycle is wrong-path.
      if (pc_src)
        discard <= outst - OW'(imem_rsp_valid);
      else if (imem_rsp_valid && discard != '0)
        discard <= discard - OW'(1);
    end
  end

  // IF/ID: flush wins, stall holds, otherwise take the head or a bubble.
  // A redirect alone does not bubble IF/ID; callers pair it with IF_flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IF_ID_valid <= 1'b0;
      IF_ID_pc    <= '0;
      IF_ID_inst  <= '0;
    end else if (IF_flush || (IF_ID_write && !pop)) begin
      IF_ID_valid <= 1'b0;
      IF_ID_pc    <= '0;
      IF_ID_inst  <= '0;
    end else if (pop) begin
      IF_ID_valid <= 1'b1;
      IF_ID_pc    <= head.pc;
      IF_ID_inst  <= head.inst;
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (pc_src),
    .alloc     (req_fire),
    .alloc_pc  (fetch_pc),
    .fill      (rsp_keep),
    .fill_data (imem_rsp_data),
    .pop       (pop),
    .head      (head),
    .not_empty (buf_not_empty),
    .full      (buf_full)
  );

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: table-driven stream/stall vectors from reset, then
// hand-written sequences for backpressure, redirect, flush+stall, wait-state
// memory and reset mid-fetch. Memory is an in-order queue with 1-cycle
// minimum latency; mem_hold freezes responses.
module tb_if_prefetch_unit;

  logic        clk, reset, pc_src, IF_flush, IF_ID_write;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] pc_branch, imem_req_addr, imem_rsp_data;
  logic        IF_ID_valid;
  logic [31:0] IF_ID_pc, IF_ID_inst;
  logic        mem_hold;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] mq[$];
  logic [31:0] hs_log[$];

  typedef struct packed {
    logic        wr;
    logic        rv;
    logic [31:0] ra;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  vec_t vt[21];

  if_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .pc_branch(pc_branch), .pc_src(pc_src),
    .IF_flush(IF_flush), .IF_ID_write(IF_ID_write),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .IF_ID_valid(IF_ID_valid),
    .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'h1000_0013 + (a << 4);
  endfunction

  function automatic vec_t mkv(input logic wr, input logic rv, input logic [31:0] ra,
                               input logic v, input logic [31:0] pc);
    vec_t r;
    r.wr = wr; r.rv = rv; r.ra = ra; r.v = v; r.pc = pc;
    return r;
  endfunction

  // Memory model: responds to the oldest accepted request, at least one
  // cycle after acceptance. Reset with the block.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      hs_log.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (mq.size() != 0 && !mem_hold) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= inst_of(mq.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
        imem_rsp_data  <= '0;
      end
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back(imem_req_addr);
        hs_log.push_back(imem_req_addr);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pc_src = 1'b0; IF_flush = 1'b0; IF_ID_write = 1'b1;
    imem_req_ready = 1'b1; pc_branch = '0; mem_hold = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset IF_ID_valid", 32'(IF_ID_valid), 32'd0);
    chk("reset IF_ID_pc", IF_ID_pc, 32'd0);
    chk("reset IF_ID_inst", IF_ID_inst, 32'd0);
    chk("reset req_valid", 32'(imem_req_valid), 32'd0);
    reset = 1'b0;
  endtask

  // Once the first valid IF/ID appears, expect n back-to-back instructions
  // starting at first_pc.
  task automatic expect_stream(input string nm, input logic [31:0] first_pc,
                               input int n, input int budget);
    int          got = 0;
    logic [31:0] e = first_pc;
    for (int c = 0; c < budget; c++) begin
      if (IF_ID_valid || got > 0) begin
        chk($sformatf("%s valid #%0d", nm, got), 32'(IF_ID_valid), 32'd1);
        if (IF_ID_valid) begin
          chk($sformatf("%s pc #%0d", nm, got), IF_ID_pc, e);
          chk($sformatf("%s inst #%0d", nm, got), IF_ID_inst, inst_of(e));
        end
        e += 32'd4;
        got++;
      end
      if (got >= n) break;
      tick();
    end
    chk($sformatf("%s count", nm), 32'(got), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cycle-by-cycle from reset: stream, stall with full buffer, release.
    vt[0]  = mkv(1, 1, 32'd0,  0, 32'd0);
    vt[1]  = mkv(1, 1, 32'd4,  0, 32'd0);
    vt[2]  = mkv(1, 1, 32'd8,  0, 32'd0);
    vt[3]  = mkv(1, 1, 32'd12, 0, 32'd0);
    vt[4]  = mkv(1, 1, 32'd16, 1, 32'd0);
    vt[5]  = mkv(1, 1, 32'd20, 1, 32'd4);
    vt[6]  = mkv(1, 1, 32'd24, 1, 32'd8);
    vt[7]  = mkv(1, 1, 32'd28, 1, 32'd12);
    vt[8]  = mkv(0, 1, 32'd32, 1, 32'd16);
    vt[9]  = mkv(0, 0, 32'd36, 1, 32'd16);
    vt[10] = mkv(0, 0, 32'd36, 1, 32'd16);
    vt[11] = mkv(0, 0, 32'd36, 1, 32'd16);
    vt[12] = mkv(0, 0, 32'd36, 1, 32'd16);
    vt[13] = mkv(0, 0, 32'd36, 1, 32'd16);
    vt[14] = mkv(1, 1, 32'd36, 1, 32'd16);
    vt[15] = mkv(1, 1, 32'd40, 1, 32'd20);
    vt[16] = mkv(1, 1, 32'd44, 1, 32'd24);
    vt[17] = mkv(1, 1, 32'd48, 1, 32'd28);
    vt[18] = mkv(1, 1, 32'd52, 1, 32'd32);
    vt[19] = mkv(1, 1, 32'd56, 1, 32'd36);
    vt[20] = mkv(1, 1, 32'd60, 1, 32'd40);

    do_reset();
    for (int i = 0; i < 21; i++) begin
      IF_ID_write = vt[i].wr;
      #1;
      chk($sformatf("vec%0d req_valid", i), 32'(imem_req_valid), 32'(vt[i].rv));
      chk($sformatf("vec%0d req_addr", i), imem_req_addr, vt[i].ra);
      chk($sformatf("vec%0d IF_ID_valid", i), 32'(IF_ID_valid), 32'(vt[i].v));
      chk($sformatf("vec%0d IF_ID_pc", i), IF_ID_pc, vt[i].pc);
      chk($sformatf("vec%0d IF_ID_inst", i), IF_ID_inst, vt[i].v ? inst_of(vt[i].pc) : 32'd0);
      tick();
    end

    // Backpressure from empty: six stalled cycles issue exactly DEPTH fetches.
    do_reset();
    IF_ID_write = 1'b0;
    repeat (6) tick();
    chk("bp req_valid at full", 32'(imem_req_valid), 32'd0);
    chk("bp request count", 32'(hs_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < hs_log.size(); i++)
      chk($sformatf("bp req addr %0d", i), hs_log[i], 32'(4 * i));
    chk("bp IF_ID held", 32'(IF_ID_valid), 32'd0);
    IF_ID_write = 1'b1;
    tick();
    expect_stream("bp resume", 32'd0, 8, 20);

    // Redirect with two unanswered requests: both responses must be dropped.
    do_reset();
    mem_hold = 1'b1;
    tick();
    tick();
    chk("redir outstanding", 32'(hs_log.size()), 32'd2);
    pc_src = 1'b1; pc_branch = 32'h40; IF_flush = 1'b1;
    #1;
    chk("redir req_valid blocked", 32'(imem_req_valid), 32'd0);
    tick();
    pc_src = 1'b0; IF_flush = 1'b0; mem_hold = 1'b0;
    #1;
    chk("redir req_valid", 32'(imem_req_valid), 32'd1);
    chk("redir req_addr", imem_req_addr, 32'h40);
    expect_stream("redirect", 32'h40, 3, 30);

    // Flush while stalled: bubble now, buffered head survives.
    do_reset();
    repeat (6) tick();
    chk("flush pre pc", IF_ID_pc, 32'd8);
    IF_flush = 1'b1; IF_ID_write = 1'b0;
    tick();
    chk("flush IF_ID_valid", 32'(IF_ID_valid), 32'd0);
    chk("flush IF_ID_inst", IF_ID_inst, 32'd0);
    chk("flush IF_ID_pc", IF_ID_pc, 32'd0);
    IF_flush = 1'b0; IF_ID_write = 1'b1;
    tick();
    expect_stream("flush resume", 32'd12, 4, 10);

    // Wait-state memory: address held, no duplicate or skipped fetch.
    do_reset();
    repeat (6) tick();
    imem_req_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ws req_valid %0d", k), 32'(imem_req_valid), 32'd1);
      chk($sformatf("ws req_addr %0d", k), imem_req_addr, 32'd24);
      tick();
    end
    imem_req_ready = 1'b1;
    repeat (12) tick();
    chk("ws request count", 32'(hs_log.size() > 12), 32'd1);
    for (int i = 0; i < hs_log.size(); i++)
      chk($sformatf("ws req addr %0d", i), hs_log[i], 32'(4 * i));

    // Reset in the middle of fetching with three entries allocated.
    do_reset();
    repeat (5) tick();
    chk("rmid pre IF_ID_pc", IF_ID_pc, 32'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("rmid IF_ID_valid", 32'(IF_ID_valid), 32'd0);
    chk("rmid IF_ID_pc", IF_ID_pc, 32'd0);
    chk("rmid IF_ID_inst", IF_ID_inst, 32'd0);
    chk("rmid req_valid", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rmid first req_valid", 32'(imem_req_valid), 32'd1);
    chk("rmid first req_addr", imem_req_addr, 32'h0);
    tick();
    chk("rmid req count", 32'(hs_log.size()), 32'd1);
    chk("rmid logged addr", hs_log.size() > 0 ? hs_log[0] : 32'hFFFF_FFFF, 32'h0);
    expect_stream("post reset", 32'd0, 4, 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: address and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch buffer entries, a power of two ≥2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address.
REQ-004 SHALL have port clk  input  1: sole clock, rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port pc_branch  input  XLEN: redirect target.
REQ-007 SHALL have port pc_src  input  1: redirect strobe, one cycle.
REQ-008 SHALL have port IF_flush  input  1: clear the IF/ID register.
REQ-009 SHALL have port IF_ID_write  input  1: decode accepts/advances IF/ID (low = stall).
REQ-010 SHALL have port imem_req_valid  output  1: fetch request.
REQ-011 SHALL have port imem_req_ready  input  1: memory accepts request.
REQ-012 SHALL have port imem_req_addr  output  XLEN: word-aligned fetch address.
REQ-013 SHALL have port imem_rsp_valid  input  1: in-order response, ≥1 cycle after acceptance.
REQ-014 SHALL have port imem_rsp_data  input  XLEN: fetched instruction.
REQ-015 SHALL have port IF_ID_valid  output  1: IF/ID holds a real instruction.
REQ-016 SHALL have port IF_ID_pc  output  XLEN: PC of IF/ID instruction.
REQ-017 SHALL have port IF_ID_inst  output  XLEN: IF/ID instruction (zero when invalid).

Function
REQ-018 SHALL keep fetch_pc; a request handshake (valid&ready) advances fetch_pc by 4 and allocates the tail buffer entry {pc, filled=0}.
REQ-019 SHALL assert imem_req_valid only when allocated entries < DEPTH and no redirect is asserted this cycle; imem_req_addr SHALL equal fetch_pc, held stable while valid&!ready.
REQ-020 SHALL fill the oldest unfilled entry with imem_rsp_data on each non-discarded response.
REQ-021 SHALL load IF/ID from the head entry when it is filled and IF_ID_write=1, freeing it; if IF_ID_write=1 and the head is unfilled or the buffer is empty, IF/ID SHALL load a bubble (valid=0, pc=0, inst=0).
REQ-022 SHALL hold IF/ID and the buffer head when IF_ID_write=0.
REQ-023 SHALL, on pc_src=1: set fetch_pc=pc_branch next cycle, free all entries, and load a discard counter with the number of accepted-but-unanswered requests.
REQ-024 SHALL drop responses while the discard counter is nonzero, decrementing it per response; a redirect during discard SHALL reload it with the current outstanding total.
REQ-025 SHALL, on IF_flush=1, load a bubble into IF/ID regardless of IF_ID_write; flush does not affect the buffer unless pc_src is also set.
REQ-026 SHALL apply pc_src and IF_flush together in the same cycle as both independent effects.
REQ-027 SHALL give a first-instruction latency of 2 cycles after response for the redirect-to-IF/ID path with zero-wait memory (redirect cycle, request cycle, response, IF/ID load).
REQ-028 SHALL sustain one instruction per cycle with 1-cycle memory latency and DEPTH≥2.
REQ-029 SHALL wrap buffer pointers modulo DEPTH and fetch_pc modulo 2^XLEN.
REQ-030 SHALL, at full (DEPTH allocated) with simultaneous free, allow a new request the same cycle.

Reset
REQ-031 SHALL, on reset: fetch_pc=RESET_PC, buffer empty, discard=0, IF_ID_valid=0, IF_ID_pc=0, IF_ID_inst=0, imem_req_valid=0.
REQ-032 SHALL abandon outstanding memory transactions on reset mid-operation; the memory model is reset together with the block.

Structure
REQ-033 SHALL put the XLEN default, the PC increment (4), and the buffer entry struct {pc, inst, filled} in shared package riscv_pkg.
REQ-034 SHALL implement the buffer as the sub-module fetch_buffer (alloc, fill, pop, clear ports); all other logic SHALL be in the top module.

Verification
REQ-035 SHALL verify streaming: reset, 1-cycle memory, IF_ID_write=1 -> IF_ID_pc 0,4,8,12 on consecutive cycles, no bubbles after fill.
REQ-036 SHALL verify backpressure: IF_ID_write=0 for 6 cycles -> exactly DEPTH=4 requests issued, IF/ID held; release -> pc resumes with no gaps or duplicates.
REQ-037 SHALL verify redirect: pc_src=1 with pc_branch=0x40 and 2 requests outstanding -> both responses dropped, next valid IF_ID_pc=0x40.
REQ-038 SHALL verify flush+stall: IF_flush=1 with IF_ID_write=0 -> IF_ID_valid=0 and IF_ID_inst=0 next cycle, buffer contents preserved.
REQ-039 SHALL verify wait-state memory: imem_req_ready low 3 cycles -> imem_req_addr stable, no duplicate fetch.
REQ-040 SHALL verify reset mid-fetch: reset asserted with 3 entries allocated -> all outputs at reset values, first request addr=RESET_PC.
